// File: rtl/mem_ctrl_4x4.sv
// Single-port 4x4-bit memory controller: three-state access sequencer
// (IDLE -> ACCESS -> DONE) in front of four 4-bit storage words.
module mem_ctrl_4x4 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [3:0] wdata,
    input  logic       clear,
    output logic       ready,
    output logic [3:0] add_sel,
    output logic       rw,
    output logic [3:0] rdata,
    output logic       rvalid,
    output logic       done
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0] state;
    logic       cap_we;
    logic [1:0] cap_addr;
    logic [3:0] cap_wdata;
    logic [3:0] mem [4];

    // clear takes the idle slot, so a simultaneous req is refused
    assign ready = (state == IDLE) && !clear && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rdata     <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            mem[i] <= '0;
                        end
                    end else if (req) begin
                        cap_we    <= we;
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cap_we) begin
                        mem[cap_addr] <= cap_wdata;
                    end else begin
                        rdata <= mem[cap_addr];
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        add_sel = '0;
        rw      = 1'b0;
        if (state == ACCESS) begin
            add_sel[cap_addr] = 1'b1;
            rw                = cap_we;
        end
    end

    assign done   = (state == DONE);
    assign rvalid = (state == DONE) && !cap_we;

endmodule
